// File: rtl/pipe_mdu.sv
// pipe_mdu: iterative multiply/divide unit with architectural HI/LO registers.
//
// The unit sits beside the EX-stage ALU and takes operands after forwarding.
// MULT/MULTU use a radix-2 shift-add loop. DIV/DIVU use a restoring radix-2
// shift-subtract loop. Both work on operand magnitudes, and a FIX cycle then
// applies the sign correction. MTHI/MTLO write HI/LO directly from IDLE.
//
// Parameters:
//   WIDTH  operand / HI / LO width (>= 4)
//   CNT_W  iteration counter width, 2**CNT_W > WIDTH
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   i_start   start request, sampled only in IDLE
//   i_op      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   i_data_1  rs: multiplicand / dividend / MTHI-MTLO source
//   i_data_2  rt: multiplier / divisor
//   i_flush   cancel in-flight op; also blocks a start in IDLE
//   o_busy    registered, high whenever state != IDLE
//   o_done    one-cycle pulse when HI/LO take a MULT/DIV result
//   o_hi      HI register
//   o_lo      LO register
//
// Optional feature: define MDU_EARLY_OUT_EN to let a multiply leave CALC as
// soon as the remaining multiplier bits are all zero. Divide timing is the
// same in both builds.

module pipe_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_data_1,
    input  logic [WIDTH-1:0] i_data_2,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Multiply: running product. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Multiplicand, shifted left once per step.
    logic [2*WIDTH-1:0]   mc_q, mc_d;
    // Multiply: multiplier, shifted right once per step. Divide: divisor.
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 div_q, div_d;
    logic                 qneg_q, qneg_d;   // product or quotient is negative
    logic                 rneg_q, rneg_d;   // remainder is negative
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Operand magnitudes. An odd opcode LSB means unsigned.
    logic             sgn_op, s1, s2;
    logic [WIDTH-1:0] abs1, abs2;
    assign sgn_op = ~i_op[0];
    assign s1     = sgn_op & i_data_1[WIDTH-1];
    assign s2     = sgn_op & i_data_2[WIDTH-1];
    assign abs1   = s1 ? (~i_data_1 + 1'b1) : i_data_1;
    assign abs2   = s2 ? (~i_data_2 + 1'b1) : i_data_2;

    // Multiply step: add the shifted multiplicand when the current multiplier bit is set.
    logic [2*WIDTH-1:0] madd;
    assign madd = acc_q + (b_q[0] ? mc_q : '0);

    // Restoring divide step. The partial remainder is shifted left and takes in
    // the next dividend bit. The divisor is subtracted only if that gives no borrow.
    logic [WIDTH:0] rs, df;
    assign rs = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign df = rs - {1'b0, b_q};

    logic last_step, mul_last;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MDU_EARLY_OUT_EN
    // Stop once no multiplier bits remain to be consumed after this step.
    assign mul_last = last_step || (b_q[WIDTH-1:1] == '0);
`else
    assign mul_last = last_step;
`endif

    // Sign correction applied in FIX.
    logic [WIDTH-1:0]   q_raw, r_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;
    assign q_raw    = acc_q[WIDTH-1:0];
    assign r_raw    = acc_q[2*WIDTH-1:WIDTH];
    assign prod_fix = qneg_q ? (~acc_q + 1'b1) : acc_q;
    assign q_fix    = qneg_q ? (~q_raw + 1'b1) : q_raw;
    assign r_fix    = rneg_q ? (~r_raw + 1'b1) : r_raw;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        b_d     = b_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start && !i_flush) begin
                    case (i_op)
                        OP_MTHI: hi_d = i_data_1;
                        OP_MTLO: lo_d = i_data_1;
                        OP_MULT, OP_MULTU: begin
                            div_d   = 1'b0;
                            qneg_d  = s1 ^ s2;
                            rneg_d  = 1'b0;
                            cnt_d   = '0;
                            acc_d   = '0;
                            mc_d    = {{WIDTH{1'b0}}, abs1};
                            b_d     = abs2;
                            state_d = S_CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            div_d = 1'b1;
                            cnt_d = '0;
                            b_d   = abs2;
                            if (i_data_2 == '0) begin
                                // Divide by zero: preload the final HI/LO and skip
                                // CALC. Sign correction is turned off.
                                acc_d   = {i_data_1, {WIDTH{1'b1}}};
                                qneg_d  = 1'b0;
                                rneg_d  = 1'b0;
                                state_d = S_FIX;
                            end else begin
                                acc_d   = {{WIDTH{1'b0}}, abs1};
                                qneg_d  = s1 ^ s2;
                                rneg_d  = s1;
                                state_d = S_CALC;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_CALC: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (div_q) begin
                        if (df[WIDTH])
                            acc_d = {rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        else
                            acc_d = {df[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        if (last_step) state_d = S_FIX;
                    end else begin
                        acc_d = madd;
                        mc_d  = mc_q << 1;
                        b_d   = b_q >> 1;
                        if (mul_last) state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                if (!i_flush) begin
                    done_d = 1'b1;
                    if (div_q) begin
                        hi_d = r_fix;
                        lo_d = q_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            b_q     <= b_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule
